shift_issue_pipe: RTL

Registered, handshaked front end for the combinational `barrel_shifter`. It accepts shift requests from the execute-stage issue logic over a valid/ready interface and buffers them in a 2-entry skid buffer. It extends the 5-bit shift amount to 6 bits with defined out-of-range semantics, then drives `barrel_shifter` and registers the result with carry and zero flags for the writeback stage. Requests complete strictly in order; latency is 2 cycles and throughput is 1 request per cycle.

---
 rtl/shift_pkg.sv | 19 +
 rtl/barrel_shifter.sv | 23 ++
 rtl/shift_skid_buf.sv | 46 ++++
 rtl/shift_issue_pipe.sv | 82 ++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: opcode constants, request type and opcode decode shared by the shift pipe.
package shift_pkg;
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam int TAG_W_MAX = 16;
  typedef enum logic [2:0] {K_SLL, K_ROL, K_SRL, K_ROR, K_SRA} kind_e;
  typedef struct packed {
    logic [31:0]          data;
    logic [2:0]           op;
    logic [5:0]           amount;
    logic [TAG_W_MAX-1:0] tag;
  } shift_req_t;
  function automatic kind_e op_kind(input logic [2:0] op);
    return op[2:1] == 2'b11 ? K_SRA : kind_e'({1'b0, op[1:0]});
  endfunction
endpackage

// File: rtl/barrel_shifter.sv
// barrel_shifter: combinational 32-bit shift/rotate by 0..31.
module barrel_shifter
  import shift_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  op,
  input  logic [4:0]  amt,
  output logic [31:0] result
);
  kind_e       k;
  logic [5:0]  inv;
  logic [31:0] sra;
  always_comb begin
    k = op_kind(op);
    inv = 6'd32 - {1'b0, amt};
    sra = $signed(data) >>> amt;
    result = k == K_SLL ? data << amt :
             k == K_SRL ? data >> amt :
             k == K_SRA ? sra :
             k == K_ROL ? (data << amt) | (data >> inv) :
                          (data >> amt) | (data << inv);
  end
endmodule

// File: rtl/shift_skid_buf.sv
// shift_skid_buf: 2-entry request FIFO with registered in_ready.
module shift_skid_buf
  import shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  shift_req_t in_req,
  input  logic       pop,
  output logic       head_valid,
  output shift_req_t head
);
  shift_req_t mem_q [2];
  shift_req_t mem_d [2];
  logic       wr_q, wr_d, rd_q, rd_d, in_ready_q, in_ready_d, push, do_pop;
  logic [1:0] count_q, count_d;
  assign in_ready   = in_ready_q;
  assign head_valid = count_q != 2'd0;
  assign head       = mem_q[rd_q];
  always_comb begin
    push = in_valid & in_ready_q;
    do_pop = pop & head_valid;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = in_req;
    wr_d = wr_q ^ push;
    rd_d = rd_q ^ do_pop;
    count_d = count_q + 2'(push) - 2'(do_pop);
    in_ready_d = count_d < 2'd2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end
endmodule

// File: rtl/shift_issue_pipe.sv
// shift_issue_pipe: handshaked skid-buffered front end for barrel_shifter with
// 6-bit amount semantics and registered result/carry/zero/tag.
module shift_issue_pipe
  import shift_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [2:0]       in_op,
  input  logic [5:0]       in_amount,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);
  shift_req_t       in_req, head;
  logic             head_valid, ld, load, big, in_rng, carry, unused_tag;
  logic [31:0]      bs_res, res;
  logic [5:0]       n;
  logic [4:0]       inv_n, n_m1;
  kind_e            k;
  logic             out_valid_q, out_valid_d, out_carry_q, out_carry_d, out_zero_q, out_zero_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  assign in_req     = '{data: in_data, op: in_op, amount: in_amount, tag: TAG_W_MAX'(in_tag)};
  assign ld         = !out_valid_q || out_ready;
  assign unused_tag = ^head.tag;
  shift_skid_buf u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req),
    .pop(ld), .head_valid(head_valid), .head(head)
  );
  barrel_shifter u_bs (.data(head.data), .op(head.op), .amt(head.amount[4:0]), .result(bs_res));
  // Amounts of 32..63 saturate logical shifts, sign-fill SRA, and wrap rotates.
  always_comb begin
    k = op_kind(head.op);
    n = head.amount;
    big = n[5];
    in_rng = n != 6'd0 && n <= 6'd32;
    inv_n = 5'(6'd32 - n);
    n_m1 = 5'(n - 6'd1);
    res = big && (k == K_SLL || k == K_SRL) ? 32'd0 :
          big && k == K_SRA ? {32{head.data[31]}} : bs_res;
    carry = n == 6'd0 ? 1'b0 :
            k == K_ROL ? res[0] :
            k == K_ROR ? res[31] :
            in_rng ? (k == K_SLL ? head.data[inv_n] : head.data[n_m1]) :
            k == K_SRA && head.data[31];
    load = ld && head_valid;
    out_valid_d = ld ? head_valid : out_valid_q;
    out_result_d = load ? res : out_result_q;
    out_carry_d = load ? carry : out_carry_q;
    out_zero_d = load ? res == 32'd0 : out_zero_q;
    out_tag_d = load ? head.tag[TAG_W-1:0] : out_tag_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_tag_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_zero_q   <= out_zero_d;
      out_tag_q    <= out_tag_d;
    end
  end
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_zero   = out_zero_q;
  assign out_tag    = out_tag_q;
endmodule
